pong_match_ctrl: RTL and testbench
==================================

// Module: pong_match_ctrl
// PURPOSE
//  Match sequencer for FPGA Pong: serve delay, rally, point pause, scoring, game over.
//  Drives the 4-bit level code consumed by the ClkDiv_Level ball-speed divider.
//  Drives ball enable/load strobes to the ball datapath; consumes its hit/miss flags.
//  Sits between the board buttons/switches and the ball/score datapath.
// PARAMETERS
//  SERVE_TICKS     3   Tick pulses spent in SERVE before ball release (1..15)
//  PAUSE_TICKS     2   Tick pulses spent in POINT after a score (1..15)
//  WIN_SCORE       9   Score that ends the match (1..15)
//  HITS_PER_LEVEL  4   Paddle hits per level increment (1..15)
//  MAX_LEVEL       10  Level saturation value (1..10, ClkDiv_Level range)
// PORTS
//  Clk        in   1  system clock, 100 MHz
//  Rst_n      in   1  asynchronous active-low reset
//  Tick       in   1  one-Clk pulse, game time base (from ClkDiv_Level edge detect)
//  Start      in   1  level, debounced start button
//  Abort      in   1  level, synchronous return to IDLE
//  Hit_l      in   1  one-Clk pulse, left paddle hit
//  Hit_r      in   1  one-Clk pulse, right paddle hit
//  Miss_l     in   1  one-Clk pulse, ball passed left edge
//  Miss_r     in   1  one-Clk pulse, ball passed right edge
//  Score_l    out  4  left score
//  Score_r    out  4  right score
//  Level      out  4  speed level, 1..MAX_LEVEL (0 only in IDLE)
//  Ball_en    out  1  ball motion enable
//  Ball_load  out  1  one-Clk pulse, recenter ball
//  Serve_dir  out  1  0 = serve toward left, 1 = toward right
//  Game_over  out  1  high in OVER
//  Winner     out  1  0 = left, 1 = right; valid while Game_over
//  State      out  3  current state code, for debug LEDs
// BEHAVIOUR
//  Reset (Rst_n=0, async): state IDLE; all outputs 0.
//  States: IDLE=0, SERVE=1, RALLY=2, POINT=3, OVER=4; codes 5..7 -> IDLE next Clk.
//  Abort=1 in any state: IDLE next Clk, all outputs cleared; overrides all else.
//  IDLE: outputs 0. Start=1 -> SERVE; scores 0, Level 1, hit count 0, Serve_dir 1.
//  SERVE: Ball_load=1 on the first SERVE cycle only; Ball_en=0; tick count cleared
//   on entry; each Tick increments it; the SERVE_TICKS-th Tick -> RALLY next Clk.
//  RALLY: Ball_en=1 (Moore, from first RALLY cycle). Hit_l|Hit_r -> hit count +1
//   (a simultaneous pair counts once); when count reaches HITS_PER_LEVEL it resets to 0
//   and Level += 1, saturating at MAX_LEVEL.
//   Miss_l alone -> Score_r+1, Serve_dir=0, -> POINT. Miss_r alone -> Score_l+1,
//   Serve_dir=1, -> POINT. Miss_l&Miss_r same cycle -> no score, Serve_dir held,
//   -> POINT. Miss has priority over Hit in the same cycle (hit not counted).
//   Hit/Miss ignored outside RALLY.
//  POINT: Ball_en=0; tick count cleared on entry; PAUSE_TICKS-th Tick -> then
//   any score==WIN_SCORE -> OVER, else SERVE with Level=1 and hit count=0.
//  OVER: Game_over=1; Winner = (Score_r==WIN_SCORE); scores/Level held.
//   Start=1 -> SERVE with the same clear as from IDLE.
//  Scores are 4-bit and never exceed WIN_SCORE; no wrap is possible.
//  Tick and a transition in the same cycle: the Tick belongs to the state being left.
//  Start held high through OVER re-arms immediately (level-sensitive, intended).
//  Latency: all outputs registered; inputs affect outputs one Clk later.
// STRUCTURE
//  Shared package pong_pkg: state codes, LEVEL_MIN=1, LEVEL_MAX_HW=10, score width 4.
//  One sub-module: pong_tick_counter (clr, Tick, terminal value -> done pulse), used
//  by SERVE and POINT; hit/level counter stays inline.
//  Single FSM always block plus registered output block; no extra clock domains.
// TESTING
//  1 Reset mid-RALLY: Rst_n low 3 Clk -> all outputs 0, State=0 asynchronously.
//  2 Start, 3 Ticks -> Ball_load pulse once, Ball_en rises after 3rd Tick, State=2.
//  3 RALLY, 8 Hit pulses (HITS_PER_LEVEL=4) -> Level 1->2->3; 40 hits -> Level stays 10.
//  4 Miss_r -> Score_l=1, Serve_dir=1, POINT; 2 Ticks -> SERVE, Level back to 1.
//  5 Miss_l&Miss_r together, also Hit_l same cycle -> scores unchanged, POINT, no hit.
//  6 Left reaches 9 -> OVER, Game_over=1, Winner=0; Start -> SERVE, scores 0; Abort -> IDLE.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared definitions for the Pong match sequencer: state codes and score/level limits.
package pong_pkg;

  localparam int SCORE_W = 4;
  localparam int LEVEL_W = 4;
  localparam logic [LEVEL_W-1:0] LEVEL_MIN    = 4'd1;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX_HW = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_RALLY = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

endpackage

// File: rtl/pong_tick_counter.sv
// Counts game-time Tick pulses since the last clear; done flags the Tick that reaches term.
module pong_tick_counter (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       clr,
  input  logic       tick,
  input  logic [3:0] term,
  output logic       done
);

  logic [3:0] cnt;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)    cnt <= 4'd0;
    else if (clr)  cnt <= 4'd0;
    else if (tick) cnt <= cnt + 4'd1;
  end

  // Combinational so the owning state can leave on the very next Clk.
  assign done = tick && (cnt == term - 4'd1);

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve delay, rally with hit-driven speed level, point pause, game over.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned SERVE_TICKS    = 3,
  parameter int unsigned PAUSE_TICKS    = 2,
  parameter int unsigned WIN_SCORE      = 9,
  parameter int unsigned HITS_PER_LEVEL = 4,
  parameter int unsigned MAX_LEVEL      = 10
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         Tick,
  input  logic         Start,
  input  logic         Abort,
  input  logic         Hit_l,
  input  logic         Hit_r,
  input  logic         Miss_l,
  input  logic         Miss_r,
  output logic [3:0]   Score_l,
  output logic [3:0]   Score_r,
  output logic [3:0]   Level,
  output logic         Ball_en,
  output logic         Ball_load,
  output logic         Serve_dir,
  output logic         Game_over,
  output logic         Winner,
  output logic [2:0]   State
);

  localparam logic [3:0] SERVE_T = 4'(SERVE_TICKS);
  localparam logic [3:0] PAUSE_T = 4'(PAUSE_TICKS);
  localparam logic [3:0] WIN     = 4'(WIN_SCORE);
  localparam logic [3:0] HPL     = 4'(HITS_PER_LEVEL);
  localparam logic [3:0] MAX_LV  = (4'(MAX_LEVEL) > LEVEL_MAX_HW) ? LEVEL_MAX_HW : 4'(MAX_LEVEL);

  state_t     state_q, state_d;
  logic [3:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic [3:0] level_q, level_d, hits_q, hits_d;
  logic       dir_q, dir_d;
  logic       ball_en_q, ball_load_q, game_over_q, winner_q;
  logic       tick_clr, tick_done;
  logic [3:0] tick_term;

  // Counter restarts on every state change, so a Tick on a transition is never carried over.
  assign tick_clr  = (state_d != state_q) || !((state_q == ST_SERVE) || (state_q == ST_POINT));
  assign tick_term = (state_q == ST_SERVE) ? SERVE_T : PAUSE_T;

  pong_tick_counter u_tick_cnt (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .clr   (tick_clr),
    .tick  (Tick),
    .term  (tick_term),
    .done  (tick_done)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    level_d   = level_q;
    hits_d    = hits_q;
    dir_d     = dir_q;
    if (Abort) begin
      state_d   = ST_IDLE;
      score_l_d = 4'd0;
      score_r_d = 4'd0;
      level_d   = 4'd0;
      hits_d    = 4'd0;
      dir_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (Start) begin
            state_d   = ST_SERVE;
            score_l_d = 4'd0;
            score_r_d = 4'd0;
            level_d   = LEVEL_MIN;
            hits_d    = 4'd0;
            dir_d     = 1'b1;
          end
        end
        ST_SERVE: begin
          if (tick_done) state_d = ST_RALLY;
        end
        ST_RALLY: begin
          // A miss ends the rally and swallows any hit reported in the same cycle.
          if (Miss_l && Miss_r) begin
            state_d = ST_POINT;
          end else if (Miss_l) begin
            state_d   = ST_POINT;
            score_r_d = score_r_q + 4'd1;
            dir_d     = 1'b0;
          end else if (Miss_r) begin
            state_d   = ST_POINT;
            score_l_d = score_l_q + 4'd1;
            dir_d     = 1'b1;
          end else if (Hit_l || Hit_r) begin
            if (hits_q == HPL - 4'd1) begin
              hits_d  = 4'd0;
              level_d = (level_q >= MAX_LV) ? MAX_LV : level_q + 4'd1;
            end else begin
              hits_d  = hits_q + 4'd1;
            end
          end
        end
        ST_POINT: begin
          if (tick_done) begin
            if ((score_l_q == WIN) || (score_r_q == WIN)) begin
              state_d = ST_OVER;
            end else begin
              state_d = ST_SERVE;
              level_d = LEVEL_MIN;
              hits_d  = 4'd0;
            end
          end
        end
        default: begin
          state_d   = ST_IDLE;
          score_l_d = 4'd0;
          score_r_d = 4'd0;
          level_d   = 4'd0;
          hits_d    = 4'd0;
          dir_d     = 1'b0;
        end
      endcase
    end
  end

  // Outputs are registered from next-state values so they line up with State.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      score_l_q   <= 4'd0;
      score_r_q   <= 4'd0;
      level_q     <= 4'd0;
      hits_q      <= 4'd0;
      dir_q       <= 1'b0;
      ball_en_q   <= 1'b0;
      ball_load_q <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
    end else begin
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      level_q     <= level_d;
      hits_q      <= hits_d;
      dir_q       <= dir_d;
      ball_en_q   <= (state_d == ST_RALLY);
      ball_load_q <= (state_d == ST_SERVE) && (state_q != ST_SERVE);
      game_over_q <= (state_d == ST_OVER);
      winner_q    <= (state_d == ST_OVER) && (score_r_d == WIN);
    end
  end

  assign Score_l   = score_l_q;
  assign Score_r   = score_r_q;
  assign Level     = level_q;
  assign Ball_en   = ball_en_q;
  assign Ball_load = ball_load_q;
  assign Serve_dir = dir_q;
  assign Game_over = game_over_q;
  assign Winner    = winner_q;
  assign State     = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl: expected output snapshots are queued per step and compared.
module tb_pong_match_ctrl;

  logic       Clk = 1'b0;
  logic       Rst_n, Tick, Start, Abort, Hit_l, Hit_r, Miss_l, Miss_r;
  logic [3:0] Score_l, Score_r, Level;
  logic       Ball_en, Ball_load, Serve_dir, Game_over, Winner;
  logic [2:0] State;

  pong_match_ctrl #(
    .SERVE_TICKS(3), .PAUSE_TICKS(2), .WIN_SCORE(9), .HITS_PER_LEVEL(4), .MAX_LEVEL(10)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Tick(Tick), .Start(Start), .Abort(Abort),
    .Hit_l(Hit_l), .Hit_r(Hit_r), .Miss_l(Miss_l), .Miss_r(Miss_r),
    .Score_l(Score_l), .Score_r(Score_r), .Level(Level), .Ball_en(Ball_en),
    .Ball_load(Ball_load), .Serve_dir(Serve_dir), .Game_over(Game_over),
    .Winner(Winner), .State(State)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       tag;
    logic [19:0] v;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   sl = 0, sr = 0, lv = 0;
  bit   dir = 1'b0;

  // Packed snapshot: {State, Score_l, Score_r, Level, Ball_en, Ball_load, Serve_dir, Game_over, Winner}
  task automatic push(input string tag, input int st, input int s_l, input int s_r, input int l,
                      input bit en, input bit ld, input bit d, input bit go, input bit w);
    exp_t e;
    e.tag = tag;
    e.v   = {3'(st), 4'(s_l), 4'(s_r), 4'(l), en, ld, d, go, w};
    q.push_back(e);
  endtask

  task automatic chk_now();
    exp_t        e;
    logic [19:0] obs;
    obs = {State, Score_l, Score_r, Level, Ball_en, Ball_load, Serve_dir, Game_over, Winner};
    vectors++;
    if (q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty observed=%h required=<queued entry>", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.v) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic clk_chk();
    @(posedge Clk);
    #1;
    Tick = 0; Start = 0; Abort = 0; Hit_l = 0; Hit_r = 0; Miss_l = 0; Miss_r = 0;
    chk_now();
  endtask

  task automatic serve_ticks();
    Tick = 1; push("serve_t1", 1, sl, sr, lv, 0, 0, dir, 0, 0); clk_chk();
    Tick = 1; push("serve_t2", 1, sl, sr, lv, 0, 0, dir, 0, 0); clk_chk();
    Tick = 1; push("serve_t3", 2, sl, sr, lv, 1, 0, dir, 0, 0); clk_chk();
  endtask

  task automatic play_round(input bit ml, input bit mr);
    serve_ticks();
    Miss_l = ml; Miss_r = mr;
    if (ml && !mr) begin sr++; dir = 1'b0; end
    else if (mr && !ml) begin sl++; dir = 1'b1; end
    push("miss", 3, sl, sr, lv, 0, 0, dir, 0, 0); clk_chk();
    Tick = 1; push("pause_t1", 3, sl, sr, lv, 0, 0, dir, 0, 0); clk_chk();
    Tick = 1;
    if (sl == 9 || sr == 9) push("over", 4, sl, sr, lv, 0, 0, dir, 1, (sr == 9));
    else                    push("reserve", 1, sl, sr, 1, 0, 1, dir, 0, 0);
    clk_chk();
    lv = 1;
  endtask

  initial begin
    Rst_n = 0; Tick = 0; Start = 0; Abort = 0; Hit_l = 0; Hit_r = 0; Miss_l = 0; Miss_r = 0;
    repeat (2) @(posedge Clk);
    #1;
    push("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0); chk_now();
    Rst_n = 1;
    push("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0); clk_chk();

    // Start and serve delay
    Start = 1; sl = 0; sr = 0; lv = 1; dir = 1;
    push("start_load", 1, 0, 0, 1, 0, 1, 1, 0, 0); clk_chk();
    push("serve_noload", 1, 0, 0, 1, 0, 0, 1, 0, 0); clk_chk();
    serve_ticks();

    // Level progression; hit 5 is a simultaneous pair counted once
    for (int i = 1; i <= 8; i++) begin
      Hit_l = 1; Hit_r = (i == 5);
      push("hit_level", 2, 0, 0, 1 + i / 4, 1, 0, 1, 0, 0); clk_chk();
    end
    for (int i = 1; i <= 40; i++) begin
      Hit_r = 1;
      lv = (3 + i / 4 > 10) ? 10 : 3 + i / 4;
      push("hit_sat", 2, 0, 0, lv, 1, 0, 1, 0, 0); clk_chk();
    end

    // Miss_r with a Tick on the transition: the Tick does not shorten the pause
    Miss_r = 1; Tick = 1; sl = 1; dir = 1;
    push("miss_r", 3, 1, 0, 10, 0, 0, 1, 0, 0); clk_chk();
    Tick = 1; push("pause_t1", 3, 1, 0, 10, 0, 0, 1, 0, 0); clk_chk();
    Tick = 1; push("pause_to_serve", 1, 1, 0, 1, 0, 1, 1, 0, 0); clk_chk();
    lv = 1;
    serve_ticks();

    // Three hits, then double miss with a hit: no score, no level step, hit ignored in POINT
    for (int i = 0; i < 3; i++) begin
      Hit_l = 1; push("pre_hits", 2, 1, 0, 1, 1, 0, 1, 0, 0); clk_chk();
    end
    Miss_l = 1; Miss_r = 1; Hit_l = 1;
    push("double_miss", 3, 1, 0, 1, 0, 0, 1, 0, 0); clk_chk();
    Hit_l = 1; push("hit_in_point", 3, 1, 0, 1, 0, 0, 1, 0, 0); clk_chk();
    Tick = 1; push("pause_t1", 3, 1, 0, 1, 0, 0, 1, 0, 0); clk_chk();
    Tick = 1; push("pause_to_serve", 1, 1, 0, 1, 0, 1, 1, 0, 0); clk_chk();

    // Right scores once, then left runs to the win
    play_round(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) play_round(1'b0, 1'b1);
    push("over_hold", 4, 9, 1, 1, 0, 0, 1, 1, 0); clk_chk();

    Start = 1; sl = 0; sr = 0; lv = 1; dir = 1;
    push("restart", 1, 0, 0, 1, 0, 1, 1, 0, 0); clk_chk();
    Abort = 1; Tick = 1; push("abort_serve", 0, 0, 0, 0, 0, 0, 0, 0, 0); clk_chk();

    // Right wins a match
    Start = 1; sl = 0; sr = 0; lv = 1; dir = 1;
    push("start2", 1, 0, 0, 1, 0, 1, 1, 0, 0); clk_chk();
    for (int i = 0; i < 9; i++) play_round(1'b1, 1'b0);
    Abort = 1; push("abort_over", 0, 0, 0, 0, 0, 0, 0, 0, 0); clk_chk();

    // Abort beats a miss in RALLY
    Start = 1; sl = 0; sr = 0; lv = 1; dir = 1;
    push("start3", 1, 0, 0, 1, 0, 1, 1, 0, 0); clk_chk();
    serve_ticks();
    Abort = 1; Miss_r = 1; push("abort_rally", 0, 0, 0, 0, 0, 0, 0, 0, 0); clk_chk();

    // Asynchronous reset in the middle of a rally
    Start = 1; push("start4", 1, 0, 0, 1, 0, 1, 1, 0, 0); clk_chk();
    serve_ticks();
    for (int i = 1; i <= 4; i++) begin
      Hit_l = 1; push("rally_hits", 2, 0, 0, 1 + i / 4, 1, 0, 1, 0, 0); clk_chk();
    end
    #3 Rst_n = 0;
    #1 push("async_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0); chk_now();
    repeat (3) @(posedge Clk);
    #1 push("reset_held", 0, 0, 0, 0, 0, 0, 0, 0, 0); chk_now();
    Rst_n = 1;
    push("idle_after_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0); clk_chk();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
